// File: rtl/dfx_packet_encap.sv
// Wraps DFX payload beats into fixed-length packets (header + NUMBER_PACKET-1 beats)
// and buffers them in a first-word fall-through FIFO for the router's input port 0.
module dfx_packet_encap #(
  parameter int AURORA_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH        = 10,
  parameter int NUMBER_PACKET     = 19,
  parameter int FIFO_DEPTH        = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         encap_start,
  input  logic [8:0]                   header_pkt_send,
  input  logic [ADDR_WIDTH-1:0]        router_dst_addr_send,
  output logic                         ready_encap_dfx,
  input  logic [AURORA_DATA_WIDTH-1:0] dfx_data_in,
  input  logic                         dfx_data_valid,
  output logic                         dfx_data_ready,
  input  logic                         rd_input_port_0,
  output logic                         empty_input_port_0,
  output logic [AURORA_DATA_WIDTH-1:0] data_input_port_0,
  output logic                         last_input_port_0,
  output logic                         encap_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int CNT_W = $clog2(NUMBER_PACKET);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUMBER_PACKET - 2);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

  state_t                       state_reg, state_next;
  logic [8:0]                   header_reg;
  logic [ADDR_WIDTH-1:0]        dst_reg;
  logic [CNT_W-1:0]             beat_reg, beat_next;
  logic [PTR_W-1:0]             wr_ptr_reg, rd_ptr_reg;
  logic [OCC_W-1:0]             occ_reg;
  logic                         encap_done_reg, encap_done_next;

  logic [AURORA_DATA_WIDTH:0]   mem [FIFO_DEPTH];
  logic [AURORA_DATA_WIDTH:0]   push_entry;
  logic [AURORA_DATA_WIDTH:0]   head_entry;
  logic [AURORA_DATA_WIDTH-1:0] header_flit;
  logic                         push, pop, space_ok, start_ok, fifo_empty;

  // Only admit a packet when all of it is guaranteed to fit, so pushes never see a full FIFO.
  always_comb begin
    space_ok   = (OCC_W'(FIFO_DEPTH) - occ_reg) >= OCC_W'(NUMBER_PACKET);
    fifo_empty = (occ_reg == '0);
    start_ok   = (state_reg == IDLE) && encap_start && space_ok && !rst;
    pop        = rd_input_port_0 && !fifo_empty;
  end

  always_comb begin
    header_flit = '0;
    header_flit[ADDR_WIDTH+8:0] = {dst_reg, header_reg};
  end

  always_comb begin
    ready_encap_dfx    = !rst && (state_reg == IDLE) && space_ok;
    dfx_data_ready     = !rst && (state_reg == PAYLOAD);
    empty_input_port_0 = rst || fifo_empty;
    head_entry         = mem[rd_ptr_reg];
    data_input_port_0  = empty_input_port_0 ? '0 : head_entry[AURORA_DATA_WIDTH-1:0];
    last_input_port_0  = empty_input_port_0 ? 1'b0 : head_entry[AURORA_DATA_WIDTH];
    encap_done         = encap_done_reg;
  end

  always_comb begin
    state_next      = state_reg;
    beat_next       = beat_reg;
    push            = 1'b0;
    push_entry      = {1'b0, header_flit};
    encap_done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_ok) state_next = HEADER;
      end
      HEADER: begin
        push       = 1'b1;
        push_entry = {1'b0, header_flit};
        beat_next  = '0;
        state_next = PAYLOAD;
      end
      PAYLOAD: begin
        if (dfx_data_valid) begin
          push       = 1'b1;
          push_entry = {(beat_reg == LAST_BEAT), dfx_data_in};
          if (beat_reg == LAST_BEAT) begin
            state_next      = IDLE;
            encap_done_next = 1'b1;
          end else begin
            beat_next = beat_reg + CNT_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      header_reg     <= '0;
      dst_reg        <= '0;
      beat_reg       <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      occ_reg        <= '0;
      encap_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      beat_reg       <= beat_next;
      encap_done_reg <= encap_done_next;
      if (start_ok) begin
        header_reg <= header_pkt_send;
        dst_reg    <= router_dst_addr_send;
      end
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ_reg <= occ_reg + OCC_W'(1);
        2'b01:   occ_reg <= occ_reg - OCC_W'(1);
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  // Storage has no reset; stale entries are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr_reg] <= push_entry;
  end

endmodule

// File: tb/tb_dfx_packet_encap.sv
// Randomized bench for dfx_packet_encap: a stimulus thread queues expected flits,
// an independent monitor pops the DUT FIFO and compares against that queue.
module tb_dfx_packet_encap;
  localparam int NP = 19;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        encap_start = 1'b0;
  logic [8:0]  header_pkt_send = '0;
  logic [9:0]  router_dst_addr_send = '0;
  logic        ready_encap_dfx;
  logic [63:0] dfx_data_in = '0;
  logic        dfx_data_valid = 1'b0;
  logic        dfx_data_ready;
  logic        rd_input_port_0 = 1'b0;
  logic        empty_input_port_0;
  logic [63:0] data_input_port_0;
  logic        last_input_port_0;
  logic        encap_done;

  dfx_packet_encap #(
    .AURORA_DATA_WIDTH(64), .ADDR_WIDTH(10), .NUMBER_PACKET(NP), .FIFO_DEPTH(32)
  ) dut (
    .clk(clk), .rst(rst), .encap_start(encap_start),
    .header_pkt_send(header_pkt_send), .router_dst_addr_send(router_dst_addr_send),
    .ready_encap_dfx(ready_encap_dfx), .dfx_data_in(dfx_data_in),
    .dfx_data_valid(dfx_data_valid), .dfx_data_ready(dfx_data_ready),
    .rd_input_port_0(rd_input_port_0), .empty_input_port_0(empty_input_port_0),
    .data_input_port_0(data_input_port_0), .last_input_port_0(last_input_port_0),
    .encap_done(encap_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        last;
    logic [63:0] data;
  } flit_t;

  flit_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int pop_mode = 0;     // 0 none, 1 every cycle, 2 random, 3 limited by pop_budget
  int pop_budget = 0;
  bit in_reset = 1'b1;
  bit watch_empty = 1'b0;
  int done_count = 0;
  int done_expected = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: decides the pop for the coming edge and checks the head it will consume.
  always @(negedge clk) begin
    flit_t e;
    if (in_reset) rd_input_port_0 = 1'b0;
    else case (pop_mode)
      1: rd_input_port_0 = 1'b1;
      2: rd_input_port_0 = 1'($urandom_range(0, 1));
      3: rd_input_port_0 = (pop_budget > 0);
      default: rd_input_port_0 = 1'b0;
    endcase
    if (encap_done === 1'b1) done_count++;
    if (watch_empty) chk("no_empty_glitch", 64'(empty_input_port_0), 64'd0);
    if (rd_input_port_0 && empty_input_port_0 === 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_flit", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("flit_data", data_input_port_0, e.data);
        chk("flit_last", 64'(last_input_port_0), 64'(e.last));
        if (pop_mode == 3) pop_budget--;
      end
    end
  end

  task automatic send_packet(input logic [8:0] hdr, input logic [9:0] dst, input int vmode,
                             input bit expect_accept, input int abort_at, input bit seq,
                             output int lat);
    logic [63:0] beat;
    logic v;
    int i;
    int it;
    lat = 0;
    @(negedge clk);
    chk("ready_before_start", 64'(ready_encap_dfx), 64'(expect_accept));
    chk("dfx_ready_idle", 64'(dfx_data_ready), 64'd0);
    encap_start = 1'b1;
    header_pkt_send = hdr;
    router_dst_addr_send = dst;
    if (expect_accept) exp_q.push_back(flit_t'({1'b0, (64'(dst) << 9) | 64'(hdr)}));
    @(posedge clk);
    #1 encap_start = 1'b0;
    if (!expect_accept) begin
      repeat (3) @(negedge clk);
      chk("reject_dfx_ready", 64'(dfx_data_ready), 64'd0);
      $display("packet hdr=%h dst=%h rejected", hdr, dst);
      return;
    end
    i = 0;
    it = 0;
    while (i < NP - 1 && it < 400) begin
      @(negedge clk);
      it++;
      if (abort_at > 0 && i == abort_at) begin
        dfx_data_valid = 1'b0;
        rst = 1'b1;
        in_reset = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        chk("rst_empty", 64'(empty_input_port_0), 64'd1);
        chk("rst_dfx_ready", 64'(dfx_data_ready), 64'd0);
        chk("rst_ready", 64'(ready_encap_dfx), 64'd0);
        chk("rst_data", data_input_port_0, 64'd0);
        rst = 1'b0;
        in_reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(ready_encap_dfx), 64'd1);
        chk("post_rst_dfx_ready", 64'(dfx_data_ready), 64'd0);
        chk("post_rst_empty", 64'(empty_input_port_0), 64'd1);
        $display("packet hdr=%h dst=%h aborted by reset after %0d beats", hdr, dst, i);
        return;
      end
      case (vmode)
        0: v = 1'b1;
        1: v = (it % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      beat = seq ? 64'(i + 1) : {$urandom, $urandom};
      dfx_data_valid = v;
      dfx_data_in = beat;
      if (v && dfx_data_ready) begin
        exp_q.push_back(flit_t'({(i == NP - 2), beat}));
        i++;
      end
    end
    chk("payload_complete", 64'(i), 64'(NP - 1));
    lat = it;
    @(negedge clk);
    dfx_data_valid = 1'b0;
    chk("encap_done_pulse", 64'(encap_done), 64'd1);
    @(negedge clk);
    chk("encap_done_single", 64'(encap_done), 64'd0);
    chk("idle_dfx_ready", 64'(dfx_data_ready), 64'd0);
    done_expected++;
    $display("packet hdr=%h dst=%h sent, %0d cycles start->last beat", hdr, dst, lat);
  endtask

  task automatic drain();
    int t = 0;
    pop_mode = 1;
    while ((exp_q.size() != 0 || empty_input_port_0 !== 1'b1) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_dut_empty", 64'(empty_input_port_0), 64'd1);
    pop_mode = 0;
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int t;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 64'(ready_encap_dfx), 64'd0);
    chk("reset_empty", 64'(empty_input_port_0), 64'd1);
    chk("reset_dfx_ready", 64'(dfx_data_ready), 64'd0);
    chk("reset_done", 64'(encap_done), 64'd0);
    chk("reset_data", data_input_port_0, 64'd0);
    chk("reset_last", 64'(last_input_port_0), 64'd0);
    rst = 1'b0;
    in_reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(ready_encap_dfx), 64'd1);

    // Single packet, no pops: leaves 19 flits so the space gate must close.
    send_packet(9'h13D, 10'h00A, 0, 1'b1, 0, 1'b1, lat);
    chk("min_packet_latency", 64'(lat), 64'(NP));
    @(negedge clk);
    chk("space_gate_closed", 64'(ready_encap_dfx), 64'd0);
    send_packet(9'h055, 10'h123, 0, 1'b0, 0, 1'b0, lat);

    pop_budget = 6;
    pop_mode = 3;
    t = 0;
    while (pop_budget > 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("pop6_done", 64'(pop_budget), 64'd0);
    pop_mode = 0;
    @(negedge clk);
    chk("space_gate_open", 64'(ready_encap_dfx), 64'd1);

    // Concurrent push/pop with 13 flits still buffered: FIFO must never look empty.
    pop_mode = 1;
    watch_empty = 1'b1;
    send_packet(9'($urandom), 10'($urandom), 0, 1'b1, 0, 1'b0, lat);
    watch_empty = 1'b0;
    drain();

    pop_mode = 2;
    send_packet(9'($urandom), 10'($urandom), 1, 1'b1, 0, 1'b1, lat);
    chk("backpressure_latency_in_range", 64'(lat >= 34 && lat <= 38), 64'd1);
    drain();

    send_packet(9'h1AA, 10'h2F0, 0, 1'b1, 7, 1'b1, lat);
    send_packet(9'h0F1, 10'h3C5, 0, 1'b1, 0, 1'b1, lat);
    drain();

    for (int p = 0; p < 4; p++) begin
      pop_mode = 2;
      send_packet(9'($urandom), 10'($urandom), 2, 1'b1, 0, 1'b0, lat);
      drain();
    end

    chk("encap_done_count", 64'(done_count), 64'(done_expected));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
